pc_sequencer: RTL and testbench

- Registered program-counter sequencer for the MIPS-32 core. Successor to the combinational jump-target concatenation.
- Holds the PC and computes PC+4, jump, branch and register targets.
- Adds stall support, a parametrised return-address stack (RAS) for jal/jr $ra, and a misaligned-target trap FSM with an acknowledge handshake.
- Sits between the control unit/register file and instruction memory.

---
 rtl/pc_pkg.sv | 15 +
 rtl/ras_stack.sv | 42 ++++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer and its return-address stack.
package pc_pkg;
   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

   typedef enum logic [2:0] {
      SEL_SEQ = 3'd0,
      SEL_BR  = 3'd1,
      SEL_J   = 3'd2,
      SEL_JR  = 3'd3,
      SEL_RET = 3'd4
   } sel_e;

   localparam int INSTR_ALIGN     = 2;
   localparam int JUMP_REGION_MSB = 28;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest entry, and the count saturates.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [XLEN-1:0]          push_data,
   output logic [XLEN-1:0]          top,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   top_idx;
   logic            empty;

   assign empty   = (count == '0);
   assign top_idx = ptr - PW'(1);
   assign top     = empty ? '0 : mem[top_idx];

   // ptr names the next free slot, so it wraps naturally and the oldest entry is overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (count != (PW+1)'(DEPTH)) count <= count + (PW+1)'(1);
      end else if (pop && !empty) begin
         ptr   <= top_idx;
         count <= count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[ptr] <= push_data;
   end
endmodule

// File: rtl/pc_sequencer.sv
// Registered MIPS-32 PC sequencer with stall, return-address stack and a misaligned-target trap.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_PC   = XLEN'(32'h0000_0180),
   parameter int              RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall_i,
   input  logic                         jump_i,
   input  logic                         jal_i,
   input  logic                         jr_i,
   input  logic                         ret_i,
   input  logic                         branch_taken_i,
   input  logic [25:0]                  instr_index_i,
   input  logic [15:0]                  branch_imm_i,
   input  logic [XLEN-1:0]              jr_target_i,
   input  logic                         trap_ack_i,
   output logic [XLEN-1:0]              pc_o,
   output logic [XLEN-1:0]              pc_plus4_o,
   output logic [XLEN-1:0]              ras_top_o,
   output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
   output logic                         misalign_o
);
   state_e          state, state_nxt;
   sel_e            sel;
   logic [XLEN-1:0] jump_tgt, br_tgt, br_off, ret_tgt, tgt;
   logic            misaligned, run_go, ras_push, ras_pop;

   assign pc_plus4_o = pc_o + XLEN'(4);
   assign jump_tgt   = {pc_plus4_o[XLEN-1:JUMP_REGION_MSB], instr_index_i, {INSTR_ALIGN{1'b0}}};
   assign br_off     = {{(XLEN-18){branch_imm_i[15]}}, branch_imm_i, 2'b00};
   assign br_tgt     = pc_plus4_o + br_off;
   assign ret_tgt    = (ras_count_o != '0) ? ras_top_o : jr_target_i;

   always_comb begin
      sel = SEL_SEQ;
      if (ret_i)                             sel = SEL_RET;
      else if (jr_i)                         sel = SEL_JR;
      else if (jal_i || jump_i)              sel = SEL_J;
      else if (branch_taken_i)               sel = SEL_BR;
   end

   always_comb begin
      tgt = pc_plus4_o;
      case (sel)
         SEL_BR:  tgt = br_tgt;
         SEL_J:   tgt = jump_tgt;
         SEL_JR:  tgt = jr_target_i;
         SEL_RET: tgt = ret_tgt;
         default: tgt = pc_plus4_o;
      endcase
   end

   // Only register-sourced targets can be misaligned; immediate targets are word-aligned by construction.
   assign misaligned = ((sel == SEL_JR) || (sel == SEL_RET)) && (|tgt[INSTR_ALIGN-1:0]);
   assign run_go     = (state == RUN) && !stall_i;
   assign ras_push   = run_go && (sel == SEL_J) && jal_i;
   assign ras_pop    = run_go && (sel == SEL_RET);

   ras_stack #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus4_o),
      .top       (ras_top_o),
      .count     (ras_count_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (run_go && misaligned) state_nxt = TRAP;
         TRAP:    if (trap_ack_i)           state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      misalign_o = (state == TRAP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          pc_o <= RESET_PC;
      else if (state == TRAP && trap_ack_i) pc_o <= TRAP_PC;
      else if (run_go && !misaligned)      pc_o <= tgt;
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
   localparam int          XLEN    = 32;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] TRP_PC  = 32'h0000_0180;
   localparam int          DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall, jump, jal, jr, ret, br, trap_ack;
   logic [25:0] idx;
   logic [15:0] imm;
   logic [31:0] jrt;
   logic [31:0] pc, pc_plus4, ras_top;
   logic [2:0]  ras_count;
   logic        misalign;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_trap;
   logic [31:0] m_ras[$];

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC), .TRAP_PC(TRP_PC), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .jump_i(jump), .jal_i(jal), .jr_i(jr),
      .ret_i(ret), .branch_taken_i(br), .instr_index_i(idx), .branch_imm_i(imm),
      .jr_target_i(jrt), .trap_ack_i(trap_ack), .pc_o(pc), .pc_plus4_o(pc_plus4),
      .ras_top_o(ras_top), .ras_count_o(ras_count), .misalign_o(misalign)
   );

   task automatic clear_inputs();
      stall = 0; jump = 0; jal = 0; jr = 0; ret = 0; br = 0; trap_ack = 0;
      idx = '0; imm = '0; jrt = '0;
   endtask

   function automatic logic [31:0] m_top();
      return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
   endfunction

   task automatic model_step();
      logic [31:0] pp4, tgt;
      logic        reg_src;
      int          off;
      pp4 = m_pc + 32'd4;
      tgt = pp4;
      reg_src = 0;
      if (m_trap) begin
         if (trap_ack) begin m_pc = TRP_PC; m_trap = 0; end
      end else if (!stall) begin
         if (ret) begin
            reg_src = 1;
            if (m_ras.size() > 0) tgt = m_ras.pop_back();
            else                  tgt = jrt;
         end else if (jr) begin
            reg_src = 1; tgt = jrt;
         end else if (jal) begin
            tgt = (pp4 & 32'hF000_0000) + 32'(idx) * 4;
            m_ras.push_back(pp4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end else if (jump) begin
            tgt = (pp4 & 32'hF000_0000) + 32'(idx) * 4;
         end else if (br) begin
            off = int'($signed(imm)) * 4;
            tgt = pp4 + 32'(off);
         end
         if (reg_src && (tgt % 4 != 0)) m_trap = 1;
         else                           m_pc = tgt;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 0;
      m_pc = RST_PC; m_trap = 0; m_ras.delete();
      #1;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic go_to(input logic [31:0] addr);
      clear_inputs(); jr = 1; jrt = addr;
      cycle();
      clear_inputs();
   endtask

   task automatic test_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 0;
      m_pc = RST_PC; m_trap = 0; m_ras.delete();
      #1;
      n_vec++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, RST_PC); end
      n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", misalign); end
      n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", ras_count); end
      n_vec++; if (ras_top !== 32'h0) begin n_err++; $display("FAIL reset_top got %h want 0", ras_top); end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      exp_pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         exp_pc = exp_pc + 32'd4;
         n_vec++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc); end
      end
      n_vec++; if (pc_plus4 !== 32'h10) begin n_err++; $display("FAIL seq_plus4 got %h want 00000010", pc_plus4); end
   endtask

   task automatic test_jal();
      apply_reset();
      go_to(32'h1000_0010);
      jal = 1; idx = 26'h0000040;
      cycle();
      clear_inputs();
      n_vec++; if (pc !== 32'h1000_0100) begin n_err++; $display("FAIL jal_pc got %h want 10000100", pc); end
      n_vec++; if (ras_top !== 32'h1000_0014) begin n_err++; $display("FAIL jal_top got %h want 10000014", ras_top); end
      n_vec++; if (ras_count !== 3'd1) begin n_err++; $display("FAIL jal_count got %0d want 1", ras_count); end
   endtask

   task automatic test_branch_stall();
      apply_reset();
      go_to(32'h0000_0020);
      br = 1; imm = 16'hFFFE; stall = 1;
      cycle();
      n_vec++; if (pc !== 32'h20) begin n_err++; $display("FAIL stall_pc got %h want 00000020", pc); end
      stall = 0;
      cycle();
      clear_inputs();
      n_vec++; if (pc !== 32'h1C) begin n_err++; $display("FAIL branch_back_pc got %h want 0000001c", pc); end
   endtask

   task automatic test_ras_saturate();
      logic [31:0] ret_addr [5];
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         ret_addr[k] = 32'(k) * 32'h400 + 32'd4;
         clear_inputs(); jal = 1; idx = 26'(32'h100 * (k + 1));
         cycle();
      end
      clear_inputs();
      n_vec++; if (ras_count !== 3'd4) begin n_err++; $display("FAIL ras_sat_count got %0d want 4", ras_count); end
      n_vec++; if (pc !== 32'h1400) begin n_err++; $display("FAIL ras_sat_pc got %h want 00001400", pc); end
      for (int k = 4; k >= 1; k--) begin
         clear_inputs(); ret = 1; jrt = 32'hDEAD_BEE0;
         cycle();
         n_vec++; if (pc !== ret_addr[k]) begin n_err++; $display("FAIL ras_pop_pc[%0d] got %h want %h", k, pc, ret_addr[k]); end
         n_vec++; if (ras_count !== 3'(k - 1)) begin n_err++; $display("FAIL ras_pop_count[%0d] got %0d want %0d", k, ras_count, k - 1); end
      end
      clear_inputs(); ret = 1; jrt = 32'h0000_0400;
      cycle();
      clear_inputs();
      n_vec++; if (pc !== 32'h400) begin n_err++; $display("FAIL ras_empty_ret got %h want 00000400", pc); end
      n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL ras_empty_count got %0d want 0", ras_count); end
   endtask

   task automatic test_trap();
      logic [31:0] held;
      apply_reset();
      go_to(32'h0000_0040);
      held = pc;
      jr = 1; jrt = 32'h0000_0402;
      cycle();
      n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL trap_hold got %h want 00000040", pc); end
      n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL trap_flag got %b want 1", misalign); end
      for (int i = 0; i < 3; i++) begin
         stall = i[0]; jump = 1; jal = 1; br = 1; jr = 1; jrt = 32'h100; idx = 26'h3FFFFFF;
         cycle();
         n_vec++; if (pc !== held || misalign !== 1'b1) begin
            n_err++; $display("FAIL trap_ignore[%0d] got pc %h mis %b want %h 1", i, pc, misalign, held);
         end
      end
      n_vec++; if (ras_count !== 3'd0) begin n_err++; $display("FAIL trap_no_push got %0d want 0", ras_count); end
      clear_inputs(); trap_ack = 1;
      cycle();
      clear_inputs();
      n_vec++; if (pc !== TRP_PC) begin n_err++; $display("FAIL trap_ack_pc got %h want %h", pc, TRP_PC); end
      n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL trap_ack_flag got %b want 0", misalign); end
   endtask

   task automatic test_reset_mid_trap();
      apply_reset();
      jal = 1; idx = 26'h40;
      cycle();
      clear_inputs(); ret = 1;
      jal = 1;
      cycle();
      clear_inputs(); jal = 1; idx = 26'h80;
      cycle();
      clear_inputs(); jr = 1; jrt = 32'h0000_0003;
      cycle();
      clear_inputs();
      n_vec++; if (misalign !== 1'b1 || ras_count !== 3'd1) begin
         n_err++; $display("FAIL pre_reset_trap got mis %b cnt %0d want 1 1", misalign, ras_count);
      end
      #1;
      rst_n = 0;
      m_pc = RST_PC; m_trap = 0; m_ras.delete();
      #1;
      n_vec++; if (pc !== RST_PC || misalign !== 1'b0 || ras_count !== 3'd0) begin
         n_err++; $display("FAIL async_reset got pc %h mis %b cnt %0d want %h 0 0", pc, misalign, ras_count, RST_PC);
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_wrap();
      apply_reset();
      go_to(32'hFFFF_FFFC);
      n_vec++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4 got %h want 0", pc_plus4); end
      cycle();
      n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 0", pc); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         clear_inputs();
         stall    = ($urandom_range(0, 99) < 15);
         ret      = ($urandom_range(0, 99) < 12);
         jr       = ($urandom_range(0, 99) < 8);
         jal      = ($urandom_range(0, 99) < 20);
         jump     = ($urandom_range(0, 99) < 10);
         br       = ($urandom_range(0, 99) < 20);
         trap_ack = ($urandom_range(0, 99) < 30);
         idx      = 26'($urandom);
         imm      = 16'($urandom);
         jrt      = $urandom;
         if ($urandom_range(0, 99) < 80) jrt[1:0] = 2'b00;
         cycle();
         n_vec++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, m_pc); end
         n_vec++; if (pc_plus4 !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_plus4[%0d] got %h want %h", i, pc_plus4, m_pc + 32'd4); end
         n_vec++; if (misalign !== m_trap) begin n_err++; $display("FAIL rnd_mis[%0d] got %b want %b", i, misalign, m_trap); end
         n_vec++; if (ras_count !== 3'(m_ras.size())) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, ras_count, m_ras.size()); end
         n_vec++; if (ras_top !== m_top()) begin n_err++; $display("FAIL rnd_top[%0d] got %h want %h", i, ras_top, m_top()); end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      m_pc = RST_PC; m_trap = 0;
      test_reset();
      test_sequential();
      test_jal();
      test_branch_stall();
      test_ras_saturate();
      test_trap();
      test_reset_mid_trap();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
